// File: rtl/alu_result_buffer.sv
// Result FIFO behind the ALU: buffers {slt,zero,carry,data} for a valid/ready consumer,
// tracks saturating zero/carry statistics and a sticky overflow for dropped results.
module alu_result_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       carry_in,
  input  logic                       zero_in,
  input  logic                       slt_in,
  input  logic                       valid_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_slt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [CNT_WIDTH-1:0]       zero_count,
  output logic [CNT_WIDTH-1:0]       carry_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 3;
  localparam logic [FILL_W-1:0]    FULL_LVL = FILL_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_zeroCnt;
  logic [CNT_WIDTH-1:0] r_carryCnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic [ENTRY_W-1:0]   w_head;

  assign w_full  = (r_fill == FULL_LVL);
  assign w_empty = (r_fill == '0);
  assign w_pop   = ~w_empty & out_ready;
  // A full FIFO still accepts a result when the head leaves on the same edge.
  assign w_push  = valid_in & (~w_full | w_pop);
  assign w_drop  = valid_in & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {slt_in, zero_in, carry_in, data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
      r_zeroCnt  <= '0;
      r_carryCnt <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - 1'b1;
      end
      // Clear beats a same-cycle drop, so that drop goes unrecorded.
      if (clr_overflow) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && zero_in && (r_zeroCnt != CNT_MAX)) begin
        r_zeroCnt <= r_zeroCnt + 1'b1;
      end
      if (w_push && carry_in && (r_carryCnt != CNT_MAX)) begin
        r_carryCnt <= r_carryCnt + 1'b1;
      end
    end
  end

  assign w_head = r_mem[r_rdPtr];
  assign {out_slt, out_zero, out_carry, out_data} = w_empty ? '0 : w_head;

  assign out_valid   = ~w_empty;
  assign fill_level  = r_fill;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_overflow;
  assign zero_count  = r_zeroCnt;
  assign carry_count = r_carryCnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue-based reference model predicts every
// popped entry and the status/statistics outputs under directed and random traffic.
module tb_alu_result_buffer;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int FILL_W    = $clog2(DEPTH) + 1;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  typedef logic [WIDTH+2:0] entry_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [WIDTH-1:0]     data_in = '0;
  logic                 carry_in = 1'b0;
  logic                 zero_in = 1'b0;
  logic                 slt_in = 1'b0;
  logic                 valid_in = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic                 out_carry;
  logic                 out_zero;
  logic                 out_slt;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [FILL_W-1:0]    fill_level;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 clr_overflow = 1'b0;
  logic [CNT_WIDTH-1:0] zero_count;
  logic [CNT_WIDTH-1:0] carry_count;

  int     nVectors = 0;
  int     nMiscompares = 0;
  entry_t expQ[$];
  int     modelFill = 0;
  bit     modelOverflow = 1'b0;
  int     modelZero = 0;
  int     modelCarry = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .carry_in(carry_in), .zero_in(zero_in), .slt_in(slt_in),
    .valid_in(valid_in),
    .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero), .out_slt(out_slt),
    .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .zero_count(zero_count), .carry_count(carry_count)
  );

  always #5 clk = ~clk;

  // Guards against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic entry_t headOut();
    return {out_slt, out_zero, out_carry, out_data};
  endfunction

  task automatic clearModel();
    expQ.delete();
    modelFill     = 0;
    modelOverflow = 1'b0;
    modelZero     = 0;
    modelCarry    = 0;
  endtask

  // Status, statistics and the presented head entry after each edge.
  task automatic checkOutput();
    checkField("fill_level", 32'(fill_level), 32'(modelFill));
    checkField("out_valid", 32'(out_valid), 32'(modelFill > 0));
    checkField("full", 32'(full), 32'(modelFill == DEPTH));
    checkField("empty", 32'(empty), 32'(modelFill == 0));
    checkField("overflow", 32'(overflow), 32'(modelOverflow));
    checkField("zero_count", 32'(zero_count), 32'(modelZero));
    checkField("carry_count", 32'(carry_count), 32'(modelCarry));
    if (modelFill > 0 && expQ.size() > 0)
      checkField("head entry", 32'(headOut()), 32'(expQ[0]));
    else
      checkField("empty outputs", 32'(headOut()), 32'd0);
  endtask

  // One clock of stimulus; the model predicts what the edge will do.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit c,
                               input bit z, input bit s, input bit rdy, input bit clr);
    bit pop, push, drop;
    valid_in     = v;
    data_in      = d;
    carry_in     = c;
    zero_in      = z;
    slt_in       = s;
    out_ready    = rdy;
    clr_overflow = clr;
    pop  = (modelFill > 0) && rdy;
    push = v && ((modelFill < DEPTH) || pop);
    drop = v && !push;
    if (push) begin
      expQ.push_back({s, z, c, d});
      if (z && modelZero < CNT_MAX) modelZero++;
      if (c && modelCarry < CNT_MAX) modelCarry++;
    end
    modelFill = modelFill + int'(push) - int'(pop);
    if (clr) modelOverflow = 1'b0;
    else if (drop) modelOverflow = 1'b1;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4 && modelFill > 0; i++)
      applyStimulus(1'b0, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    rst          = 1'b1;
    valid_in     = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clearModel();
    checkOutput();
    rst = 1'b0;
  endtask

  // Monitor: every handshake consumes the oldest predicted entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkField("pop with empty scoreboard", 32'd1, 32'd0);
      end else begin
        checkField("popped entry", 32'(headOut()), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    doReset();

    // Single result, consumer stalled.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill, then one dropped result.
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, WIDTH'(8'hA0 + i), i[0], 1'b0, i[1], 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous push and pop, pointers wrap.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, WIDTH'(8'hB0 + i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear beats a same-cycle drop; then set and clear again.
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Zero statistic saturation under continuous draining.
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'($urandom), 1'b1, 1'b0);
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), WIDTH'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 19) == 0));
    drain();

    // Asynchronous reset mid-cycle with three entries in flight.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, WIDTH'(8'hD0 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkField("async rst out_valid", 32'(out_valid), 32'd0);
    checkField("async rst fill_level", 32'(fill_level), 32'd0);
    checkField("async rst zero_count", 32'(zero_count), 32'd0);
    checkField("async rst carry_count", 32'(carry_count), 32'd0);
    clearModel();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    checkField("scoreboard empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
